player_ctrl_multi: RTL

//  Parametrised successor to the single-level player controller for the road-crossing game.

---
 rtl/player_ctrl_multi.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/player_ctrl_multi.sv
// Player controller for the road-crossing game: grid movement, multi-lane collision, lives/level/speed.
// Optional build macro GRACE_EN adds a post-respawn collision grace window and a 'grace' output.
module player_ctrl_multi #(
    parameter int NUM_CARS   = 8,
    parameter int MAX_LIVES  = 4,
    parameter int STEP       = 32,
    parameter int MOVE_TICKS = 2500000,
    parameter int MAX_SPEED  = 31,
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int PW         = 32,
    parameter int PH         = 32,
    parameter int CW         = 64,
    parameter int CH         = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SW1,
    input  logic                     SW2,
    input  logic                     SW3,
    input  logic                     SW4,
    input  logic [10*NUM_CARS-1:0]   car_x,
    input  logic [10*NUM_CARS-1:0]   car_y,
    input  logic [NUM_CARS-1:0]      car_en,
    output logic [9:0]               player_x,
    output logic [9:0]               player_y,
    output logic [MAX_LIVES-1:0]     lives,
    output logic [7:0]               level_bcd,
    output logic [6:0]               seg_tens,
    output logic [6:0]               seg_units,
    output logic [4:0]               speed_car,
    output logic                     game_over
`ifdef GRACE_EN
    ,
    output logic                     grace
`endif
);

    localparam int CNT_W = $clog2(MOVE_TICKS + 1);
    localparam logic [9:0] X0 = 10'(H_DISP / 2);
    localparam logic [9:0] Y0 = 10'(V_DISP - PH);

    typedef enum logic [1:0] {
        S_PLAY     = 2'd0,
        S_HIT      = 2'd1,
        S_GAMEOVER = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [9:0]           px_q, py_q;
    logic [MAX_LIVES-1:0] lives_q;
    logic [7:0]           level_q, level_d;
    logic [4:0]           speed_q, speed_d;
    logic [6:0]           seg_tens_q, seg_units_q;
    logic                 hit_q, game_over_q;
    logic                 hit_c, hit_eff, restart_c, wrap_c;
    logic                 up_ok, dn_ok, lt_ok, rt_ok;

`ifdef GRACE_EN
    localparam int GRACE_CYCLES = 2 * MOVE_TICKS;
    localparam int GRACE_W      = $clog2(GRACE_CYCLES + 1);
    logic [GRACE_W-1:0] grace_q;
    assign hit_eff = hit_c && (grace_q == '0);
    assign grace   = (grace_q != '0);
`else
    assign hit_eff = hit_c;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h01;
            4'd1:    seg7 = 7'h4F;
            4'd2:    seg7 = 7'h12;
            4'd3:    seg7 = 7'h06;
            4'd4:    seg7 = 7'h4C;
            4'd5:    seg7 = 7'h24;
            4'd6:    seg7 = 7'h20;
            4'd7:    seg7 = 7'h0F;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h04;
            default: seg7 = 7'h7E;
        endcase
    endfunction

    assign restart_c = SW1 && SW2 && SW3 && SW4;
    assign wrap_c    = (cnt_q == CNT_W'(MOVE_TICKS - 1));

    assign up_ok = ({1'b0, py_q} >= 11'(STEP));
    assign dn_ok = ({1'b0, py_q} + 11'(STEP) <= 11'(V_DISP - PH));
    assign lt_ok = ({1'b0, px_q} >= 11'(STEP));
    assign rt_ok = ({1'b0, px_q} + 11'(STEP) <= 11'(H_DISP - PW));

    // Strict AABB overlap against every enabled lane; all sums carried in 11 bits.
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (car_en[i] &&
                ({1'b0, px_q} + 11'(PW) > {1'b0, car_x[10*i +: 10]}) &&
                ({1'b0, px_q} < {1'b0, car_x[10*i +: 10]} + 11'(CW)) &&
                ({1'b0, py_q} + 11'(PH) > {1'b0, car_y[10*i +: 10]}) &&
                ({1'b0, py_q} < {1'b0, car_y[10*i +: 10]} + 11'(CH)))
                hit_c = 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        if (level_q != 8'h99) begin
            if (level_q[3:0] >= 4'd9) level_d = {level_q[7:4] + 4'd1, 4'd0};
            else                      level_d = {level_q[7:4], level_q[3:0] + 4'd1};
        end
        speed_d = (speed_q >= 5'(MAX_SPEED)) ? speed_q : speed_q + 5'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST || restart_c) begin
            state_q     <= S_PLAY;
            cnt_q       <= '0;
            px_q        <= X0;
            py_q        <= Y0;
            lives_q     <= '1;
            level_q     <= 8'h00;
            speed_q     <= 5'd0;
            seg_tens_q  <= 7'h01;
            seg_units_q <= 7'h01;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
`ifdef GRACE_EN
            grace_q     <= RST ? '0 : GRACE_W'(GRACE_CYCLES);
`endif
        end else begin
            seg_tens_q  <= seg7(level_q[7:4]);
            seg_units_q <= seg7(level_q[3:0]);
`ifdef GRACE_EN
            if (grace_q != '0) grace_q <= grace_q - GRACE_W'(1);
`endif
            case (state_q)
                S_PLAY: begin
                    if (hit_q) begin
                        state_q <= S_HIT;
                        hit_q   <= 1'b0;
                    end else if (py_q == 10'd0) begin
                        level_q <= level_d;
                        speed_q <= speed_d;
                        px_q    <= X0;
                        py_q    <= Y0;
                        hit_q   <= 1'b0;
`ifdef GRACE_EN
                        grace_q <= GRACE_W'(GRACE_CYCLES);
`endif
                    end else begin
                        hit_q <= hit_eff;
                        cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
                        if (wrap_c) begin
                            if      (SW1 && up_ok) py_q <= py_q - 10'(STEP);
                            else if (SW2 && dn_ok) py_q <= py_q + 10'(STEP);
                            else if (SW3 && lt_ok) px_q <= px_q - 10'(STEP);
                            else if (SW4 && rt_ok) px_q <= px_q + 10'(STEP);
                        end
                    end
                end
                S_HIT: begin
                    lives_q <= lives_q >> 1;
                    px_q    <= X0;
                    py_q    <= Y0;
                    cnt_q   <= '0;
                    hit_q   <= 1'b0;
`ifdef GRACE_EN
                    grace_q <= GRACE_W'(GRACE_CYCLES);
`endif
                    if (lives_q == MAX_LIVES'(1)) begin
                        state_q     <= S_GAMEOVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q <= S_PLAY;
                    end
                end
                S_GAMEOVER: begin
                    hit_q       <= 1'b0;
                    game_over_q <= 1'b1;
                end
                default: state_q <= S_PLAY;
            endcase
        end
    end

    assign player_x  = px_q;
    assign player_y  = py_q;
    assign lives     = lives_q;
    assign level_bcd = level_q;
    assign seg_tens  = seg_tens_q;
    assign seg_units = seg_units_q;
    assign speed_car = speed_q;
    assign game_over = game_over_q;

endmodule
